// File: rtl/uart_pkg.sv
// Shared encodings and defaults for the UART Rx frame checker slice.
package uart_pkg;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_CNT_WIDTH = 8;

  typedef enum logic [2:0] {
    PAR_NONE  = 3'd0,
    PAR_EVEN  = 3'd1,
    PAR_ODD   = 3'd2,
    PAR_MARK  = 3'd3,
    PAR_SPACE = 3'd4
  } par_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } rx_state_e;

  // Reserved encodings 5..7 behave as no parity.
  function automatic par_mode_e norm_par_mode(input logic [2:0] mode);
    return (mode > 3'd4) ? PAR_NONE : par_mode_e'(mode);
  endfunction

endpackage

// File: rtl/uart_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module uart_sat_cnt #(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 inc_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/uart_rx_frame_chk.sv
// UART Rx frame assembler: data/parity/stop checking with saturating error counters.
// Optional break detection is enabled by defining UART_RX_BREAK_DET_EN.
module uart_rx_frame_chk
  import uart_pkg::*;
#(
  parameter  int unsigned WIDTH     = DEF_WIDTH,
  parameter  int unsigned CNT_WIDTH = DEF_CNT_WIDTH,
  localparam int unsigned LEN_WIDTH = $clog2(WIDTH + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Start,
  input  logic                 Bit_Valid,
  input  logic                 Sampled_Bit,
  input  logic [LEN_WIDTH-1:0] Data_Len,
  input  logic [2:0]           Par_Mode,
  input  logic                 Two_Stop,
  input  logic                 Cnt_Clr,
  output logic [WIDTH-1:0]     P_DATA,
  output logic                 Frame_Done,
  output logic                 Par_Err,
  output logic                 Stp_Err,
  output logic                 Busy,
  output logic [CNT_WIDTH-1:0] Par_Err_Cnt,
  output logic [CNT_WIDTH-1:0] Stp_Err_Cnt,
  output logic                 Brk_Det
);

  rx_state_e            state_q, state_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d, cnt_nxt;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  par_mode_e            mode_q, mode_d;
  logic                 two_q, two_d;
  logic                 par_q, par_d;
  logic                 pperr_q, pperr_d;
  logic                 pserr_q, pserr_d;
  logic                 done_q, done_d;
  logic                 perr_q, perr_d;
  logic                 serr_q, serr_d;
  logic                 exp_par;
  logic                 fin;
`ifdef UART_RX_BREAK_DET_EN
  logic                 any_q, any_d;
  logic                 brk_q, brk_d;
`endif

  assign cnt_nxt = cnt_q + 1'b1;

  always_comb begin
    case (mode_q)
      PAR_EVEN: exp_par = par_q;
      PAR_ODD:  exp_par = ~par_q;
      PAR_MARK: exp_par = 1'b1;
      default:  exp_par = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    mode_d  = mode_q;
    two_d   = two_q;
    par_d   = par_q;
    pperr_d = pperr_q;
    pserr_d = pserr_q;
    done_d  = 1'b0;
    perr_d  = perr_q;
    serr_d  = serr_q;
    fin     = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    any_d   = any_q;
    brk_d   = brk_q;
`endif
    if (Start) begin
      state_d = ST_DATA;
      data_d  = '0;
      cnt_d   = '0;
      par_d   = 1'b0;
      pperr_d = 1'b0;
      pserr_d = 1'b0;
      perr_d  = 1'b0;
      serr_d  = 1'b0;
      len_d   = ((Data_Len == '0) || (Data_Len > LEN_WIDTH'(WIDTH))) ? LEN_WIDTH'(WIDTH) : Data_Len;
      mode_d  = norm_par_mode(Par_Mode);
      two_d   = Two_Stop;
`ifdef UART_RX_BREAK_DET_EN
      any_d   = 1'b0;
      brk_d   = 1'b0;
`endif
    end else if (Bit_Valid) begin
`ifdef UART_RX_BREAK_DET_EN
      if (state_q != ST_IDLE) any_d = any_q | Sampled_Bit;
`endif
      case (state_q)
        ST_DATA: begin
          for (int unsigned i = 0; i < WIDTH; i++) begin
            if (cnt_q == LEN_WIDTH'(i)) data_d[i] = Sampled_Bit;
          end
          par_d = par_q ^ Sampled_Bit;
          cnt_d = cnt_nxt;
          if (cnt_nxt == len_q) state_d = (mode_q == PAR_NONE) ? ST_STOP1 : ST_PARITY;
        end
        ST_PARITY: begin
          pperr_d = (Sampled_Bit != exp_par);
          state_d = ST_STOP1;
        end
        ST_STOP1: begin
          pserr_d = ~Sampled_Bit;
          if (two_q) state_d = ST_STOP2;
          else       fin     = 1'b1;
        end
        ST_STOP2: begin
          pserr_d = pserr_q | ~Sampled_Bit;
          fin     = 1'b1;
        end
        default: ;
      endcase
    end

    if (fin) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
      perr_d  = pperr_d;
      serr_d  = pserr_d;
`ifdef UART_RX_BREAK_DET_EN
      // An all-zero frame is a line break, not a framing/parity fault.
      brk_d = ~any_d;
      if (~any_d) begin
        perr_d = 1'b0;
        serr_d = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      mode_q  <= PAR_NONE;
      two_q   <= 1'b0;
      par_q   <= 1'b0;
      pperr_q <= 1'b0;
      pserr_q <= 1'b0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      serr_q  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      any_q   <= 1'b0;
      brk_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      two_q   <= two_d;
      par_q   <= par_d;
      pperr_q <= pperr_d;
      pserr_q <= pserr_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
      serr_q  <= serr_d;
`ifdef UART_RX_BREAK_DET_EN
      any_q   <= any_d;
      brk_q   <= brk_d;
`endif
    end
  end

  uart_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_par_cnt (
    .clk_i (CLK),
    .rst_i (RST),
    .clr_i (Cnt_Clr),
    .inc_i (done_q & perr_q),
    .cnt_o (Par_Err_Cnt)
  );

  uart_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_stp_cnt (
    .clk_i (CLK),
    .rst_i (RST),
    .clr_i (Cnt_Clr),
    .inc_i (done_q & serr_q),
    .cnt_o (Stp_Err_Cnt)
  );

  assign P_DATA     = data_q;
  assign Frame_Done = done_q;
  assign Par_Err    = perr_q;
  assign Stp_Err    = serr_q;
  assign Busy       = (state_q != ST_IDLE);
`ifdef UART_RX_BREAK_DET_EN
  assign Brk_Det    = brk_q;
`else
  assign Brk_Det    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame_chk.sv
// Self-checking bench for uart_rx_frame_chk (WIDTH=8, CNT_WIDTH=8) against a frame-level reference model.
module tb_uart_rx_frame_chk;

  logic       CLK = 1'b0;
  logic       RST;
  logic       Start, Bit_Valid, Sampled_Bit, Two_Stop, Cnt_Clr;
  logic [3:0] Data_Len;
  logic [2:0] Par_Mode;
  logic [7:0] P_DATA, Par_Err_Cnt, Stp_Err_Cnt;
  logic       Frame_Done, Par_Err, Stp_Err, Busy, Brk_Det;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  int unsigned done_cnt = 0;
  int unsigned pcnt = 0;
  int unsigned scnt = 0;

  uart_rx_frame_chk #(.WIDTH(8), .CNT_WIDTH(8)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .Start       (Start),
    .Bit_Valid   (Bit_Valid),
    .Sampled_Bit (Sampled_Bit),
    .Data_Len    (Data_Len),
    .Par_Mode    (Par_Mode),
    .Two_Stop    (Two_Stop),
    .Cnt_Clr     (Cnt_Clr),
    .P_DATA      (P_DATA),
    .Frame_Done  (Frame_Done),
    .Par_Err     (Par_Err),
    .Stp_Err     (Stp_Err),
    .Busy        (Busy),
    .Par_Err_Cnt (Par_Err_Cnt),
    .Stp_Err_Cnt (Stp_Err_Cnt),
    .Brk_Det     (Brk_Det)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (Frame_Done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one complete frame and checks it against the reference model.
  task automatic run_frame(input logic [7:0] d, input int unsigned len_in, input int unsigned mode_in,
                           input bit two, input bit pbit, input bit s1, input bit s2, input bit clr);
    int unsigned eff_len, eff_mode, ones, done0;
    logic [7:0]  exp_d;
    bit          exp_pb, perr, serr, brk;
    bit          bits[$];
    eff_len  = (len_in == 0 || len_in > 8) ? 8 : len_in;
    eff_mode = (mode_in > 4) ? 0 : mode_in;
    exp_d = '0;
    ones  = 0;
    for (int i = 0; i < int'(eff_len); i++) begin
      exp_d[i] = d[i];
      ones += d[i];
      bits.push_back(d[i]);
    end
    case (eff_mode)
      1:       exp_pb = (ones % 2 == 1);
      2:       exp_pb = (ones % 2 == 0);
      3:       exp_pb = 1'b1;
      default: exp_pb = 1'b0;
    endcase
    perr = (eff_mode != 0) && (pbit != exp_pb);
    if (eff_mode != 0) bits.push_back(pbit);
    bits.push_back(s1);
    if (two) bits.push_back(s2);
    serr = !s1 || (two && !s2);
    brk  = (exp_d == 0) && (eff_mode == 0 || !pbit) && !s1 && (!two || !s2);
`ifdef UART_RX_BREAK_DET_EN
    if (brk) begin
      perr = 1'b0;
      serr = 1'b0;
    end
`else
    brk = 1'b0;
`endif

    @(negedge CLK);
    Start = 1; Data_Len = len_in[3:0]; Par_Mode = mode_in[2:0]; Two_Stop = two;
    Bit_Valid = 1'($urandom_range(0, 1)); Sampled_Bit = 1'($urandom_range(0, 1));
    done0 = done_cnt;
    @(negedge CLK);
    Start = 0; Bit_Valid = 0;
    Data_Len = 4'($urandom); Par_Mode = 3'($urandom); Two_Stop = 1'($urandom);
    check("busy_after_start", Busy, 1);
    check("par_err_clr_on_start", Par_Err, 0);
    check("stp_err_clr_on_start", Stp_Err, 0);
    for (int i = 0; i < bits.size(); i++) begin
      repeat ($urandom_range(0, 2)) begin
        Sampled_Bit = 1'($urandom);
        @(negedge CLK);
      end
      Bit_Valid = 1; Sampled_Bit = bits[i];
      @(negedge CLK);
      Bit_Valid = 0;
    end
    check("frame_done", Frame_Done, 1);
    check("p_data", P_DATA, exp_d);
    check("par_err", Par_Err, perr);
    check("stp_err", Stp_Err, serr);
    check("brk_det", Brk_Det, brk);
    check("busy_done", Busy, 0);
    Cnt_Clr = clr;
    @(negedge CLK);
    Cnt_Clr = 0;
    if (clr) begin
      pcnt = 0;
      scnt = 0;
    end else begin
      if (perr && pcnt < 255) pcnt++;
      if (serr && scnt < 255) scnt++;
    end
    check("frame_done_pulse", Frame_Done, 0);
    check("done_count", done_cnt - done0, 1);
    check("par_err_cnt", Par_Err_Cnt, pcnt);
    check("stp_err_cnt", Stp_Err_Cnt, scnt);
    check("p_data_hold", P_DATA, exp_d);
    check("par_err_hold", Par_Err, perr);
  endtask

  task automatic start_partial(input int unsigned k);
    @(negedge CLK);
    Start = 1; Data_Len = 4'd8; Par_Mode = 3'd1; Two_Stop = 0;
    @(negedge CLK);
    Start = 0;
    for (int unsigned i = 0; i < k; i++) begin
      Bit_Valid = 1; Sampled_Bit = 1'($urandom);
      @(negedge CLK);
      Bit_Valid = 0;
    end
  endtask

  initial begin
    int unsigned d0;
    RST = 1; Start = 0; Bit_Valid = 0; Sampled_Bit = 0; Data_Len = 0;
    Par_Mode = 0; Two_Stop = 0; Cnt_Clr = 0;
    repeat (3) @(negedge CLK);
    check("rst_p_data", P_DATA, 0);
    check("rst_frame_done", Frame_Done, 0);
    check("rst_par_err", Par_Err, 0);
    check("rst_stp_err", Stp_Err, 0);
    check("rst_busy", Busy, 0);
    check("rst_par_cnt", Par_Err_Cnt, 0);
    check("rst_stp_cnt", Stp_Err_Cnt, 0);
    check("rst_brk", Brk_Det, 0);
    RST = 0;

    repeat (3) begin
      @(negedge CLK);
      Bit_Valid = 1; Sampled_Bit = 1;
    end
    @(negedge CLK);
    Bit_Valid = 0;
    check("idle_bits_busy", Busy, 0);
    check("idle_bits_data", P_DATA, 0);
    check("idle_bits_done", Frame_Done, 0);

    run_frame(8'hA5, 8, 1, 0, 0, 1, 1, 0);
    run_frame(8'hA5, 8, 2, 0, 0, 1, 1, 0);
    run_frame(8'h3C, 7, 0, 1, 0, 1, 0, 0);
    run_frame(8'h00, 8, 3, 0, 1, 1, 1, 0);
    run_frame(8'h00, 8, 4, 0, 1, 1, 1, 0);

    d0 = done_cnt;
    start_partial(3);
    run_frame(8'h5A, 8, 1, 0, 0, 1, 1, 0);
    check("abort_single_done", done_cnt - d0, 1);

    run_frame(8'h00, 8, 1, 0, 0, 0, 0, 0);
    run_frame(8'h00, 8, 1, 0, 0, 0, 0, 1);
    run_frame(8'hFF, 0, 6, 1, 0, 1, 1, 0);
    run_frame(8'h81, 12, 2, 0, 1, 1, 1, 0);

    for (int n = 0; n < 60; n++) begin
      if (n % 7 == 3) begin
        d0 = done_cnt;
        start_partial($urandom_range(0, 6));
        run_frame(8'($urandom), $urandom_range(0, 15), $urandom_range(0, 7), 1'($urandom),
                  1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 0);
        check("rand_abort_done", done_cnt - d0, 1);
      end else begin
        run_frame(8'($urandom), $urandom_range(0, 15), $urandom_range(0, 7), 1'($urandom),
                  1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) == 0);
      end
    end

    for (int n = 0; n < 260; n++) run_frame(8'hA5, 8, 2, 0, 0, 0, 1, 0);
    check("par_cnt_saturated", Par_Err_Cnt, 8'hFF);
    check("stp_cnt_saturated", Stp_Err_Cnt, 8'hFF);

    start_partial(4);
    #2 RST = 1;
    #1;
    pcnt = 0;
    scnt = 0;
    check("async_rst_busy", Busy, 0);
    check("async_rst_data", P_DATA, 0);
    check("async_rst_par_cnt", Par_Err_Cnt, pcnt);
    check("async_rst_stp_cnt", Stp_Err_Cnt, scnt);
    @(negedge CLK);
    RST = 0;
    run_frame(8'h3C, 8, 2, 0, 0, 1, 1, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_chk.md
Name: uart_rx_frame_chk

Overview:
- Parametrised successor to the Rx parity checker.
- Assembles a whole UART frame from per-bit samples: data, parity and stop bits.
- Computes parity on the fly and checks parity plus 1 or 2 stop bits.
- Keeps saturating error counters.
- Sits between the Rx bit sampler (one majority-voted bit per Bit_Valid) and the Rx FSM / deserializer consumer.

Parameters:
- WIDTH, 8, maximum data bits per frame; P_DATA width.
- CNT_WIDTH, 8, width of each saturating error counter.
- LEN_WIDTH, $clog2(WIDTH+1), width of Data_Len (localparam-derived, not overridden).

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-high reset
- Start  in  1  pulse: start bit confirmed; latches config, enters DATA
- Bit_Valid  in  1  pulse: Sampled_Bit holds the next frame bit
- Sampled_Bit  in  1  majority-voted bit value
- Data_Len  in  LEN_WIDTH  data bits per frame (1..WIDTH)
- Par_Mode  in  3  0 none, 1 even, 2 odd, 3 mark(1), 4 space(0)
- Two_Stop  in  1  1 = two stop bits expected
- Cnt_Clr  in  1  synchronous clear of both counters
- P_DATA  out  WIDTH  received data, LSB first, right-aligned, upper bits 0
- Frame_Done  out  1  one-cycle pulse, frame complete
- Par_Err  out  1  valid with Frame_Done, held until next Frame_Done/Start
- Stp_Err  out  1  valid with Frame_Done, held likewise
- Busy  out  1  state != IDLE
- Par_Err_Cnt  out  CNT_WIDTH  saturating count of parity errors
- Stp_Err_Cnt  out  CNT_WIDTH  saturating count of stop errors
- Brk_Det  out  1  break detected (optional feature)

Behaviour:
- Reset: all outputs 0, state IDLE, running parity 0, latched config 0.
- Config latch: Data_Len, Par_Mode and Two_Stop are latched on Start; changes mid-frame are ignored. Data_Len 0 or >WIDTH is latched as WIDTH. Par_Mode 5..7 is treated as none.
- FSM states: IDLE, DATA, PARITY, STOP1, STOP2.
  - IDLE -> DATA on Start. Clear P_DATA, bit counter, running parity, Par_Err, Stp_Err.
  - DATA: each Bit_Valid shifts Sampled_Bit into P_DATA[bit_cnt] and XORs it into running parity. After the Data_Len-th bit: -> PARITY if mode != none, else -> STOP1.
  - PARITY: on Bit_Valid, expected = even: ^data; odd: ~^data; mark: 1; space: 0. Par_Err_next = (Sampled_Bit != expected). -> STOP1.
  - STOP1: on Bit_Valid, Stp_Err_next = ~Sampled_Bit. -> STOP2 if Two_Stop, else -> IDLE with done.
  - STOP2: on Bit_Valid, Stp_Err_next |= ~Sampled_Bit. -> IDLE with done.
- Latency: Frame_Done, Par_Err and Stp_Err are registered. They assert the cycle after the Bit_Valid of the final stop bit.
- Counters: increment on Frame_Done when the matching error is set.
  - Saturate at all-ones.
  - Cnt_Clr wins over a simultaneous increment (counter reads 0 next cycle).
- Start while Busy: abort the current frame with no Frame_Done and no counter update, then restart DATA with the freshly latched config.
- Start and Bit_Valid in the same cycle: Start wins and the bit is discarded.
- Bit_Valid in IDLE: ignored.
- P_DATA is stable from Frame_Done until the next Start.
- Async RST mid-frame: immediate return to IDLE. Counters cleared.

Optional Feature:
- Macro: UART_RX_BREAK_DET_EN.
- Enabled: break = all data bits 0, parity bit 0 (if a parity bit is present) and stop bit(s) 0.
  - Asserts Brk_Det with Frame_Done.
  - Stp_Err and Par_Err are forced to 0 for that frame; counters are not incremented.
  - Brk_Det is held like Par_Err.
- Disabled: Brk_Det tied 0; such a frame reports Stp_Err = 1 (and Par_Err per mode).

Decomposition:
- Shared package uart_pkg holds:
  - Par_Mode encodings: PAR_NONE, PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE;
  - FSM state encodings;
  - default WIDTH/CNT_WIDTH constants.
- One natural sub-module, uart_sat_cnt: parametrised saturating counter with inc/clr, instanced twice.

Test Plan:
- WIDTH=8, Data_Len=8, even parity, 1 stop; frame 0xA5, par 0, stop 1 -> P_DATA=0xA5, Frame_Done pulse, Par_Err=0, Stp_Err=0, counters 0.
- Same frame, odd parity, par bit 0 -> Par_Err=1, Par_Err_Cnt=1. Repeat 256 times with CNT_WIDTH=8 -> count holds at 0xFF.
- Data_Len=7, no parity, Two_Stop=1; data 0x3C, stops 1,0 -> P_DATA=0x3C, Stp_Err=1, Stp_Err_Cnt=1, Frame_Done one cycle after the 2nd stop Bit_Valid.
- Mark parity, data 0x00, par bit 1, stop 1 -> no errors. Space parity with par bit 1 -> Par_Err=1.
- Start after 3 data bits of a frame, then a full 0x5A frame -> exactly one Frame_Done, P_DATA=0x5A, counters unchanged from the aborted frame.
- Break (UART_RX_BREAK_DET_EN): 8 zero data bits, even parity, par 0, stop 0 -> Brk_Det=1, Stp_Err=0, counters unchanged. Without the macro -> Stp_Err=1, Stp_Err_Cnt increments. Assert Cnt_Clr in the same cycle -> counter reads 0.
